// File: rtl/prng_lfsr_gen_if.sv
// Control, seed and output signals of the Galois-LFSR PRNG.
// The master drives control and seed; the slave (the generator) drives the random byte and status.
interface prng_lfsr_gen_if;
   logic       ena;
   logic [1:0] mode;
   logic       step;
   logic       seed_valid;
   logic [7:0] seed_byte;
   logic [7:0] rnd_out;
   logic       rnd_valid;
   logic       seed_busy;

   modport master (
      output ena, mode, step, seed_valid, seed_byte,
      input  rnd_out, rnd_valid, seed_busy
   );

   modport slave (
      input  ena, mode, step, seed_valid, seed_byte,
      output rnd_out, rnd_valid, seed_busy
   );
endinterface

// File: rtl/prng_lfsr_gen.sv
// Galois-LFSR PRNG with byte-serial seed loading and HOLD/FREE/STEP/BYTE run modes.
// Define PRNG_WHITEN_EN to XOR the top state byte into the FREE/STEP output byte.
module prng_lfsr_gen #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
   input logic            clk,
   input logic            rst_n,
   prng_lfsr_gen_if.slave bus
);
   localparam int unsigned      NBYTES   = WIDTH / 8;
   localparam int unsigned      CNT_W    = $clog2(NBYTES) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);
   localparam logic [1:0]       MODE_HOLD = 2'd0;
   localparam logic [1:0]       MODE_FREE = 2'd1;
   localparam logic [1:0]       MODE_STEP = 2'd2;
   localparam logic [1:0]       MODE_BYTE = 2'd3;

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] seed_sr_r;
   logic [CNT_W-1:0] seed_cnt_r;
   logic [2:0]       bit_cnt_r;
   logic [7:0]       pack_r;
   logic [1:0]       mode_q_r;
   logic [7:0]       rnd_out_r;
   logic             rnd_valid_r;

   logic [WIDTH-1:0] state_nxt_s;
   logic [WIDTH-1:0] seed_sr_nxt_s;
   logic             mode_chg_s;
   logic             do_step_s;
   logic [2:0]       bit_idx_s;
   logic [7:0]       pack_new_s;

   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      lfsr_step = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
   endfunction

   function automatic logic [7:0] out_map(input logic [WIDTH-1:0] s);
`ifdef PRNG_WHITEN_EN
      out_map = s[7:0] ^ s[WIDTH-1:WIDTH-8];
`else
      out_map = s[7:0];
`endif
   endfunction

   // Next-state helpers: LFSR step, seed shift and the BYTE-mode packing slot.
   always_comb begin
      state_nxt_s   = lfsr_step(state_r);
      seed_sr_nxt_s = {seed_sr_r[WIDTH-9:0], bus.seed_byte};
      mode_chg_s    = (bus.mode != mode_q_r);
      // A mode change restarts packing in the same cycle that the new mode steps.
      if (mode_chg_s) begin
         bit_idx_s  = 3'd0;
         pack_new_s = {7'd0, state_r[0]};
      end else begin
         bit_idx_s  = bit_cnt_r;
         pack_new_s = pack_r | ({7'd0, state_r[0]} << bit_cnt_r);
      end
      if (bus.seed_valid || (seed_cnt_r != '0)) begin
         do_step_s = 1'b0;
      end else begin
         case (bus.mode)
            MODE_HOLD: do_step_s = 1'b0;
            MODE_FREE: do_step_s = 1'b1;
            MODE_STEP: do_step_s = bus.step;
            MODE_BYTE: do_step_s = 1'b1;
            default:   do_step_s = 1'b0;
         endcase
      end
   end

   // Seed loading has priority over generation; ena low freezes everything but rnd_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= SEED;
         seed_sr_r   <= '0;
         seed_cnt_r  <= '0;
         bit_cnt_r   <= 3'd0;
         pack_r      <= 8'h00;
         mode_q_r    <= MODE_HOLD;
         rnd_out_r   <= 8'h00;
         rnd_valid_r <= 1'b0;
      end else if (bus.ena) begin
         mode_q_r    <= bus.mode;
         rnd_valid_r <= 1'b0;
         if (mode_chg_s) begin
            bit_cnt_r <= 3'd0;
            pack_r    <= 8'h00;
         end
         if (bus.seed_valid) begin
            seed_sr_r <= seed_sr_nxt_s;
            if (seed_cnt_r == LAST_CNT) begin
               state_r    <= (seed_sr_nxt_s == '0) ? SEED : seed_sr_nxt_s;
               seed_cnt_r <= '0;
               bit_cnt_r  <= 3'd0;
               pack_r     <= 8'h00;
            end else begin
               seed_cnt_r <= seed_cnt_r + CNT_W'(1);
            end
         end else if (do_step_s) begin
            state_r <= state_nxt_s;
            if (bus.mode == MODE_BYTE) begin
               if (bit_idx_s == 3'd7) begin
                  rnd_out_r   <= pack_new_s;
                  rnd_valid_r <= 1'b1;
                  bit_cnt_r   <= 3'd0;
                  pack_r      <= 8'h00;
               end else begin
                  bit_cnt_r <= bit_idx_s + 3'd1;
                  pack_r    <= pack_new_s;
               end
            end else begin
               rnd_out_r   <= out_map(state_nxt_s);
               rnd_valid_r <= 1'b1;
            end
         end
      end else begin
         rnd_valid_r <= 1'b0;
      end
   end

   assign bus.rnd_out   = rnd_out_r;
   assign bus.rnd_valid = rnd_valid_r;
   assign bus.seed_busy = (seed_cnt_r != '0);
endmodule

// File: tb/tb_prng_lfsr_gen.sv
// Self-checking bench for prng_lfsr_gen: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_prng_lfsr_gen;
   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [15:0] SEED = 16'hACE1;
`ifdef PRNG_WHITEN_EN
   localparam logic [7:0] FREE1_RND = 8'h92;
   localparam logic [7:0] FREE2_RND = 8'h49;
   localparam logic [7:0] STEP1_RND = 8'h13;
`else
   localparam logic [7:0] FREE1_RND = 8'h70;
   localparam logic [7:0] FREE2_RND = 8'h38;
   localparam logic [7:0] STEP1_RND = 8'h1A;
`endif

   logic clk = 1'b0;
   logic rst_n;
   prng_lfsr_gen_if bus ();

   prng_lfsr_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: seed bytes and packed bits kept as queues.
   logic [15:0] m_state;
   logic [7:0]  m_rnd;
   logic        m_valid;
   logic [1:0]  m_mode_prev;
   logic [7:0]  seed_q[$];
   bit          bits_q[$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] m_next(input logic [15:0] s);
      int unsigned v;
      v = int'(s) / 2;
      if ((int'(s) % 2) == 1) v = v ^ int'(TAPS);
      return v[15:0];
   endfunction

   function automatic logic [7:0] m_f(input logic [15:0] s);
`ifdef PRNG_WHITEN_EN
      return s[7:0] ^ s[15:8];
`else
      return s[7:0];
`endif
   endfunction

   task automatic model_reset();
      m_state     = SEED;
      m_rnd       = 8'h00;
      m_valid     = 1'b0;
      m_mode_prev = 2'd0;
      seed_q.delete();
      bits_q.delete();
   endtask

   task automatic model_update(input logic ena, input logic [1:0] mode, input logic step,
                               input logic sv, input logic [7:0] sb);
      logic [15:0] val;
      logic [7:0]  b;
      m_valid = 1'b0;
      if (!ena) return;
      if (mode != m_mode_prev) bits_q.delete();
      m_mode_prev = mode;
      if (sv) begin
         seed_q.push_back(sb);
         if (seed_q.size() == 2) begin
            val = 16'h0000;
            foreach (seed_q[i]) val = (val << 8) | {8'h00, seed_q[i]};
            m_state = (val == 16'h0000) ? SEED : val;
            seed_q.delete();
            bits_q.delete();
         end
      end else if (seed_q.size() == 0) begin
         if (mode == 2'd1 || (mode == 2'd2 && step)) begin
            m_state = m_next(m_state);
            m_rnd   = m_f(m_state);
            m_valid = 1'b1;
         end else if (mode == 2'd3) begin
            bits_q.push_back(m_state[0]);
            m_state = m_next(m_state);
            if (bits_q.size() == 8) begin
               b = 8'h00;
               for (int i = 0; i < 8; i++) if (bits_q[i]) b[i] = 1'b1;
               m_rnd   = b;
               m_valid = 1'b1;
               bits_q.delete();
            end
         end
      end
   endtask

   task automatic compare_all();
      check_eq("rnd_out",   bus.rnd_out,   m_rnd);
      check_eq("rnd_valid", bus.rnd_valid, m_valid);
      check_eq("seed_busy", bus.seed_busy, seed_q.size() != 0);
      check_eq("state",     dut.state_r,   m_state);
   endtask

   task automatic drive(input logic ena, input logic [1:0] mode, input logic step,
                        input logic sv, input logic [7:0] sb);
      bus.ena        = ena;
      bus.mode       = mode;
      bus.step       = step;
      bus.seed_valid = sv;
      bus.seed_byte  = sb;
      @(posedge clk);
      model_update(ena, mode, step, sv, sb);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [15:0] saved_state;
   logic [7:0]  saved_rnd;
   logic [1:0]  r_mode;

   initial begin
      bus.ena = 1'b0; bus.mode = 2'd0; bus.step = 1'b0;
      bus.seed_valid = 1'b0; bus.seed_byte = 8'h00;
      rst_n = 1'b1;
      #2;
      do_reset();
      check_eq("reset_state", dut.state_r, 16'hACE1);
      check_eq("reset_rnd", bus.rnd_out, 8'h00);

      // FREE from reset
      drive(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
      check_eq("free1_state", dut.state_r, 16'hE270);
      check_eq("free1_rnd", bus.rnd_out, FREE1_RND);
      check_eq("free1_valid", bus.rnd_valid, 1'b1);
      drive(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
      check_eq("free2_state", dut.state_r, 16'h7138);
      check_eq("free2_rnd", bus.rnd_out, FREE2_RND);

      // Seed 12 34 then one STEP
      do_reset();
      drive(1'b1, 2'd2, 1'b0, 1'b1, 8'h12);
      check_eq("seed_busy_1", bus.seed_busy, 1'b1);
      drive(1'b1, 2'd2, 1'b0, 1'b1, 8'h34);
      check_eq("seed_commit", dut.state_r, 16'h1234);
      drive(1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
      check_eq("step_state", dut.state_r, 16'h091A);
      check_eq("step_rnd", bus.rnd_out, STEP1_RND);
      check_eq("step_valid", bus.rnd_valid, 1'b1);
      drive(1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
      check_eq("step_pulse_end", bus.rnd_valid, 1'b0);

      // Seed and step together: step dropped
      drive(1'b1, 2'd2, 1'b1, 1'b1, 8'hAB);
      drive(1'b1, 2'd2, 1'b1, 1'b1, 8'hCD);
      check_eq("seed_step_state", dut.state_r, 16'hABCD);
      check_eq("seed_step_valid", bus.rnd_valid, 1'b0);

      // Zero seed falls back to SEED
      drive(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
      check_eq("zero_seed_valid0", bus.rnd_valid, 1'b0);
      drive(1'b1, 2'd1, 1'b0, 1'b1, 8'h00);
      check_eq("zero_seed_state", dut.state_r, 16'hACE1);
      check_eq("zero_seed_valid1", bus.rnd_valid, 1'b0);

      // BYTE from reset
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
         check_eq("byte_valid", bus.rnd_valid, i == 7);
      end
      check_eq("byte_rnd", bus.rnd_out, 8'hE1);
      check_eq("byte_state", dut.state_r, 16'hC2C4);

      // Partial byte interrupted by a mode switch
      for (int i = 0; i < 4; i++) drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
         check_eq("reentry_valid", bus.rnd_valid, i == 7);
      end

      // ena low freezes
      drive(1'b1, 2'd1, 1'b0, 1'b0, 8'h00);
      saved_state = m_state;
      saved_rnd   = m_rnd;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 2'd1, 1'b0, 1'b1, 8'h55);
         check_eq("ena_state", dut.state_r, saved_state);
         check_eq("ena_rnd", bus.rnd_out, saved_rnd);
         check_eq("ena_valid", bus.rnd_valid, 1'b0);
      end

      // Reset mid-load
      drive(1'b1, 2'd1, 1'b0, 1'b1, 8'h77);
      check_eq("midload_busy", bus.seed_busy, 1'b1);
      do_reset();
      check_eq("midload_busy_rst", bus.seed_busy, 1'b0);
      check_eq("midload_state_rst", dut.state_r, 16'hACE1);

      // Randomized traffic
      r_mode = 2'd1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 9) == 0) r_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) do_reset();
         drive($urandom_range(0, 7) != 0, r_mode, 1'($urandom_range(0, 1)),
               $urandom_range(0, 11) == 0,
               ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/prng_lfsr_gen.md
# prng_lfsr_gen

Parametrised Galois-LFSR pseudo-random generator, the next generation of the team's Tiny Tapeout PRNG. It adds a configurable width and polynomial, byte-serial seed loading with zero-seed protection, and four run modes (hold, free-run, single-step, byte-pack). The block sits behind the `tt_um_*` top wrapper: ui/uio pins map onto its control and seed ports, and `uo_out` carries `rnd_out`.

## Interface
- `WIDTH`, 16 — LFSR state width in bits; multiple of 8, range 16..64.
- `TAPS`, 16'hB400 — Galois feedback mask, WIDTH bits; bit WIDTH-1 must be set.
- `SEED`, 16'hACE1 — reset/fallback state, WIDTH bits, non-zero.

- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `ena` in 1 — global enable; low freezes all registers except reset.
- `mode` in 2 — 0 HOLD, 1 FREE, 2 STEP, 3 BYTE.
- `step` in 1 — STEP mode advance request, level-sampled each cycle.
- `seed_valid` in 1 — `seed_byte` valid this cycle; always accepted.
- `seed_byte` in 8 — seed data, MSB byte first.
- `rnd_out` out 8 — registered random byte.
- `rnd_valid` out 1 — one-cycle pulse: `rnd_out` updated this cycle.
- `seed_busy` out 1 — a partial seed is in the load register.

## Operation
- Step function: `state <= state[0] ? (state>>1) ^ TAPS : state>>1`.
- Registers: `state` (WIDTH), `seed_sr` (WIDTH), `seed_cnt` (log2(WIDTH/8)+1 bits), `bit_cnt` (3 bits), `pack` (8 bits), `mode_q` (2 bits).
- Seed load has priority over generation:
  - Each `seed_valid` cycle: `seed_sr <= {seed_sr[WIDTH-9:0], seed_byte}`, and `seed_cnt` increments.
  - On the WIDTH/8-th byte, assembled value commits to `state`. An all-zero value commits `SEED` instead.
  - On commit: `seed_cnt`, `bit_cnt` and `pack` clear.
  - No step occurs on any `seed_valid` cycle or while `seed_busy`=1.
  - `seed_busy` = (`seed_cnt` != 0).
- HOLD: no steps; `rnd_out` holds; `rnd_valid`=0.
- FREE: one step per enabled cycle. `rnd_out <= f(next state)` and `rnd_valid`=1 every step cycle.
- STEP: one step per cycle with `step`=1. `rnd_out <= f(next state)` and `rnd_valid` pulses.
- BYTE: one step per cycle.
  - Pre-step `state[0]` is packed into `pack` LSB-first at index `bit_cnt`.
  - On the 8th bit, `rnd_out <= completed byte` and `rnd_valid` pulses; `bit_cnt` wraps to 0.
- f(s) = `s[7:0]`, modified by configuration (see below).
- A change of `mode` (`mode` != `mode_q`) clears `bit_cnt` and `pack`. The step for the new mode still occurs that cycle.
- `ena`=0: no register changes (seed bytes ignored); `rnd_valid`=0.

## Timing
- Reset values:
  - `state`=SEED
  - `rnd_out`=8'h00, `rnd_valid`=0, `seed_busy`=0
  - `seed_cnt`=0, `bit_cnt`=0, `pack`=0, `mode_q`=0
- FREE/STEP latency: 1 cycle. `rnd_out` after edge k reflects state after k steps.
- BYTE: `rnd_valid` pulses on the edge of every 8th step; minimum 8 cycles between pulses.
- Seed commit is visible in `state` the cycle after the last byte. Generation resumes on the following edge.
- Reset asserted mid-load or mid-byte discards the partial seed and the partial byte.
- `seed_valid` and `step` in the same cycle: the seed byte is taken and the step is dropped.

## Configuration
- `PRNG_WHITEN_EN` defined: f(s) = `s[7:0] ^ s[WIDTH-1:WIDTH-8]` in FREE and STEP. BYTE output is unaffected.
- `PRNG_WHITEN_EN` undefined: f(s) = `s[7:0]`; no XOR logic is present.

## Test plan
All scenarios use the defaults (WIDTH=16, TAPS=16'hB400, SEED=16'hACE1).
- Reset, then FREE with `ena`=1 for 2 cycles -> state E270 then 7138; `rnd_out` 8'h70 then 8'h38; `rnd_valid`=1 both cycles. With `PRNG_WHITEN_EN`: first `rnd_out`=8'h92.
- Seed bytes 8'h12, 8'h34, then STEP with `step`=1 for one cycle:
  - `seed_busy`=1 after the first byte; state = 1234 after commit.
  - After the step: state 091A, `rnd_out`=8'h1A, one `rnd_valid` pulse.
- Seed bytes 8'h00, 8'h00 -> state = ACE1; no `rnd_valid` during the load.
- BYTE from reset for 8 cycles -> `rnd_valid` only on the 8th edge, `rnd_out`=8'hE1, state = C2C4.
- BYTE for 4 cycles, then a mode switch to FREE and back to BYTE:
  - The packed count restarts.
  - The next `rnd_valid` comes exactly 8 BYTE cycles after re-entry.
- FREE with `ena` toggled low for 3 cycles -> state and `rnd_out` frozen, `rnd_valid`=0. Assert `rst_n` low mid-seed-load -> `seed_busy`=0, state ACE1.
